dl_sequencer: RTL and testbench

- Controls the ROM/DIP download path and core reset sequencing for the arcade core top level.
- Takes the hps_io ioctl stream and routes ROM bytes to the core's dn_* write port.
- Latches the DIP switch byte.
- Holds the game core in reset during ROM load and for a fixed stretch afterwards.
- Qualifies user reset requests, and flags short or oversized ROM images so a bad load never releases the CPU.

---
 rtl/dl_sequencer_pkg.sv | 18 +
 rtl/dl_sequencer_if.sv | 25 ++
 rtl/dl_sequencer_rst_stretch.sv | 28 ++
 rtl/dl_sequencer.sv | 137 +++++++++++++
 tb/tb_dl_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dl_sequencer_pkg.sv
// Shared types and constants for the ROM/DIP download sequencer.
package dl_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } seq_state_t;

  localparam logic [7:0] DEF_ROM_INDEX = 8'd0;
  localparam logic [7:0] DEF_DIP_INDEX = 8'd254;

  localparam int IOCTL_AW = 25;
  localparam int DN_AW    = 19;

endpackage

// File: rtl/dl_sequencer_if.sv
// hps_io download stream in, core ROM write port out.
interface dl_sequencer_if;
  import dl_sequencer_pkg::*;

  logic                ioctl_download;
  logic                ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0]          ioctl_dout;
  logic [7:0]          ioctl_index;

  logic [DN_AW-1:0]    dn_addr;
  logic [7:0]          dn_data;
  logic                dn_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr
  );

endinterface

// File: rtl/dl_sequencer_rst_stretch.sv
// Loadable down-counter that times how long the core reset is stretched.
module rst_stretch #(
  parameter int HOLD = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int             W      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [W-1:0]   RELOAD = W'(HOLD - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/dl_sequencer.sv
// Routes ROM bytes to the core, latches DIP switches and sequences the core reset.
module dl_sequencer
  import dl_sequencer_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = DEF_ROM_INDEX,
  parameter logic [7:0]  DIP_INDEX   = DEF_DIP_INDEX,
  parameter logic [23:0] ROM_BYTES   = 24'h01C000,
  parameter int          RST_HOLD    = 1024,
  parameter logic [7:0]  DIP_DEFAULT = 8'h00
) (
  input  logic         clk_sys,
  input  logic         reset,
  dl_sequencer_if.slave bus,
  input  logic         user_reset,
  output logic [7:0]   dip_sw,
  output logic         core_reset_n,
  output logic         rom_loaded,
  output logic         rom_size_err
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic        download_q;
  logic [23:0] byte_cnt;
  logic        overrun;
  logic        rom_start;
  logic        rom_end;
  logic        rom_wr;
  logic        in_range;
  logic        dip_wr;
  logic        size_ok;
  logic        hold_load;
  logic        hold_done;

  assign rom_start = bus.ioctl_download && !download_q && (bus.ioctl_index == ROM_INDEX);
  assign rom_end   = !bus.ioctl_download && download_q && (bus.ioctl_index == ROM_INDEX)
                     && (state == LOAD);
  assign rom_wr    = bus.ioctl_wr && (bus.ioctl_index == ROM_INDEX) && (state == LOAD);
  assign in_range  = bus.ioctl_addr < {1'b0, ROM_BYTES};
  assign dip_wr    = bus.ioctl_wr && (bus.ioctl_index == DIP_INDEX) && (bus.ioctl_addr == '0);
  assign size_ok   = (byte_cnt == ROM_BYTES) && !overrun;

  rst_stretch #(
    .HOLD (RST_HOLD)
  ) u_hold (
    .clk   (clk_sys),
    .reset (reset),
    .load  (hold_load),
    .done  (hold_done)
  );

  // A ROM start pre-empts every state, including a restart of LOAD itself.
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    if (rom_start) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (rom_end) begin
            if (size_ok) begin
              state_next = HOLD;
              hold_load  = 1'b1;
            end else begin
              state_next = ERR;
            end
          end
        end
        HOLD: begin
          if (user_reset) begin
            hold_load = 1'b1;
          end else if (hold_done) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (user_reset) begin
            state_next = HOLD;
            hold_load  = 1'b1;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= IDLE;
      // Follow the live level so a download still running across reset is not seen as a new start.
      download_q   <= bus.ioctl_download;
      bus.dn_addr  <= '0;
      bus.dn_data  <= '0;
      bus.dn_wr    <= 1'b0;
      dip_sw       <= DIP_DEFAULT;
      core_reset_n <= 1'b0;
      rom_loaded   <= 1'b0;
      rom_size_err <= 1'b0;
      byte_cnt     <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_next;
      download_q   <= bus.ioctl_download;
      core_reset_n <= (state_next == RUN);
      bus.dn_wr    <= rom_wr && in_range;
      if (rom_wr && in_range) begin
        bus.dn_addr <= bus.ioctl_addr[DN_AW-1:0];
        bus.dn_data <= bus.ioctl_dout;
      end
      if (dip_wr) begin
        dip_sw <= bus.ioctl_dout;
      end
      if (rom_start) begin
        byte_cnt     <= '0;
        overrun      <= 1'b0;
        rom_loaded   <= 1'b0;
        rom_size_err <= 1'b0;
      end else begin
        if (rom_wr && in_range && (byte_cnt != '1)) begin
          byte_cnt <= byte_cnt + 24'd1;
        end
        if (rom_wr && !in_range) begin
          overrun <= 1'b1;
        end
        if (rom_end) begin
          if (size_ok) begin
            rom_loaded <= 1'b1;
          end else begin
            rom_size_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dl_sequencer.sv
// Randomized bench for dl_sequencer checked every cycle against an event-level model.
module tb_dl_sequencer;
  import dl_sequencer_pkg::*;

  localparam logic [23:0] ROM_BYTES = 24'd300;
  localparam int          RST_HOLD  = 1024;
  localparam logic [7:0]  ROM_IDX   = 8'd0;
  localparam logic [7:0]  DIP_IDX   = 8'd254;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       user_reset;
  logic [7:0] dip_sw;
  logic       core_reset_n;
  logic       rom_loaded;
  logic       rom_size_err;

  dl_sequencer_if bus();

  dl_sequencer #(
    .ROM_BYTES (ROM_BYTES),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .bus          (bus),
    .user_reset   (user_reset),
    .dip_sw       (dip_sw),
    .core_reset_n (core_reset_n),
    .rom_loaded   (rom_loaded),
    .rom_size_err (rom_size_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int wr_pulses = 0;
  bit model_live = 1'b0;

  // Model: a load is "active" between its rising and falling download edge; once a
  // good load ends the core is "armed" and runs from release_at on.
  bit         m_prev_dl, m_active, m_armed, m_loaded, m_err, m_over, m_wr;
  int         m_bytes, release_at;
  logic [18:0] m_addr;
  logic [7:0]  m_data, m_dip;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk_sys) begin
    edge_cnt++;
    model_live = 1'b1;
    m_wr = 1'b0;
    if (reset) begin
      m_prev_dl  = bus.ioctl_download;
      m_active   = 1'b0;
      m_armed    = 1'b0;
      m_loaded   = 1'b0;
      m_err      = 1'b0;
      m_over     = 1'b0;
      m_bytes    = 0;
      release_at = 0;
      m_addr     = '0;
      m_data     = '0;
      m_dip      = 8'h00;
    end else begin
      if (bus.ioctl_wr && bus.ioctl_index == DIP_IDX && bus.ioctl_addr == 25'd0)
        m_dip = bus.ioctl_dout;
      if (m_active && bus.ioctl_wr && bus.ioctl_index == ROM_IDX) begin
        if (int'(bus.ioctl_addr) < int'(ROM_BYTES)) begin
          m_wr   = 1'b1;
          m_addr = bus.ioctl_addr[18:0];
          m_data = bus.ioctl_dout;
          m_bytes++;
        end else begin
          m_over = 1'b1;
        end
      end
      if (bus.ioctl_download && !m_prev_dl && bus.ioctl_index == ROM_IDX) begin
        m_active = 1'b1;
        m_armed  = 1'b0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_over   = 1'b0;
        m_bytes  = 0;
      end else if (!bus.ioctl_download && m_prev_dl && m_active) begin
        m_active = 1'b0;
        if (m_bytes == int'(ROM_BYTES) && !m_over) begin
          m_loaded   = 1'b1;
          m_armed    = 1'b1;
          release_at = edge_cnt + RST_HOLD;
        end else begin
          m_err = 1'b1;
        end
      end else if (m_armed && user_reset) begin
        release_at = edge_cnt + RST_HOLD;
      end
      m_prev_dl = bus.ioctl_download;
    end
  end

  always @(negedge clk_sys) begin
    if (model_live) begin
      checkOutput("dn_wr", 32'(bus.dn_wr), 32'(m_wr));
      checkOutput("dn_addr", 32'(bus.dn_addr), 32'(m_addr));
      checkOutput("dn_data", 32'(bus.dn_data), 32'(m_data));
      checkOutput("dip_sw", 32'(dip_sw), 32'(m_dip));
      checkOutput("core_reset_n", 32'(core_reset_n), 32'(m_armed && (edge_cnt >= release_at)));
      checkOutput("rom_loaded", 32'(rom_loaded), 32'(m_loaded));
      checkOutput("rom_size_err", 32'(rom_size_err), 32'(m_err));
      if (bus.dn_wr === 1'b1) wr_pulses++;
    end
  end

  task automatic applyStimulus(input logic dl, input logic wr, input logic [24:0] addr,
                               input logic [7:0] dout, input logic [7:0] idx, input logic ures);
    @(negedge clk_sys);
    bus.ioctl_download = dl;
    bus.ioctl_wr       = wr;
    bus.ioctl_addr     = addr;
    bus.ioctl_dout     = dout;
    bus.ioctl_index    = idx;
    user_reset         = ures;
  endtask

  task automatic idleCycles(input int n, input logic dl, input logic [7:0] idx);
    repeat (n) applyStimulus(dl, 1'b0, 25'd0, 8'h00, idx, 1'b0);
  endtask

  task automatic romLoad(input int n_bytes, input bit extra_byte, input string name);
    int start_pulses;
    start_pulses = wr_pulses;
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    for (int a = 0; a < n_bytes; a++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
      applyStimulus(1'b1, 1'b1, 25'(a), 8'($urandom), ROM_IDX, 1'b0);
    end
    if (extra_byte) applyStimulus(1'b1, 1'b1, 25'(ROM_BYTES), 8'($urandom), ROM_IDX, 1'b0);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    checkOutput(name, 32'(wr_pulses - start_pulses), 32'(n_bytes));
  endtask

  // Counts falling clock edges from now until core_reset_n is seen high (bounded).
  task automatic waitRelease(input int ures_len, output int cnt);
    cnt = 0;
    if (ures_len > 0) user_reset = 1'b1;
    do begin
      @(negedge clk_sys);
      cnt++;
      if (cnt == ures_len) user_reset = 1'b0;
    end while (core_reset_n !== 1'b1 && cnt < 5000);
    user_reset = 1'b0;
  endtask

  initial begin
    int cnt;
    int len;
    reset = 1'b1;
    user_reset = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.ioctl_index = '0;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_core_reset_n", 32'(core_reset_n), 32'd0);
    checkOutput("reset_dip_sw", 32'(dip_sw), 32'h00);
    checkOutput("reset_dn_wr", 32'(bus.dn_wr), 32'd0);
    checkOutput("reset_rom_loaded", 32'(rom_loaded), 32'd0);
    reset = 1'b0;
    idleCycles(4, 1'b0, ROM_IDX);

    // ROM writes with no download running must be dropped.
    repeat (5) applyStimulus(1'b0, 1'b1, 25'($urandom_range(0, 299)), 8'($urandom), ROM_IDX, 1'b0);
    idleCycles(2, 1'b0, ROM_IDX);

    romLoad(300, 1'b0, "exact_dn_wr_count");
    waitRelease(0, cnt);
    // Fall is sampled one edge after it is driven, then RST_HOLD cycles of reset.
    checkOutput("exact_release_cycles", 32'(cnt), 32'd1025);
    checkOutput("exact_rom_loaded", 32'(rom_loaded), 32'd1);

    applyStimulus(1'b0, 1'b1, 25'd0, 8'hA5, DIP_IDX, 1'b0);
    idleCycles(1, 1'b0, DIP_IDX);
    checkOutput("dip_a5", 32'(dip_sw), 32'hA5);
    applyStimulus(1'b0, 1'b1, 25'd3, 8'h5A, DIP_IDX, 1'b0);
    idleCycles(1, 1'b0, DIP_IDX);
    checkOutput("dip_addr3_ignored", 32'(dip_sw), 32'hA5);
    checkOutput("dip_core_running", 32'(core_reset_n), 32'd1);

    // Randomized DIP download and a foreign-index download while running.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, DIP_IDX, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 25'($urandom_range(0, 2)), 8'($urandom), DIP_IDX, 1'b0);
    idleCycles(2, 1'b0, DIP_IDX);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, 8'd7, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 25'($urandom_range(0, 299)), 8'($urandom), 8'd7, 1'b0);
    idleCycles(3, 1'b0, 8'd7);

    waitRelease(10, cnt);
    checkOutput("user_reset_10_release", 32'(cnt), 32'd1034);
    repeat (3) begin
      idleCycles($urandom_range(1, 5), 1'b0, ROM_IDX);
      len = $urandom_range(1, 20);
      waitRelease(len, cnt);
      checkOutput("user_reset_rand_release", 32'(cnt), 32'(len + RST_HOLD));
    end

    // ROM start while in HOLD.
    applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b1);
    idleCycles(50, 1'b0, ROM_IDX);
    romLoad(300, 1'b0, "hold_restart_dn_wr_count");
    // ROM start lands on the last HOLD cycle.
    idleCycles(RST_HOLD - 1, 1'b0, ROM_IDX);
    romLoad(300, 1'b0, "final_hold_dn_wr_count");
    waitRelease(0, cnt);
    checkOutput("final_hold_release_cycles", 32'(cnt), 32'd1025);

    romLoad(299, 1'b0, "short_dn_wr_count");
    repeat (5000) applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM_IDX, ($urandom_range(0, 9) == 0));
    checkOutput("short_size_err", 32'(rom_size_err), 32'd1);
    checkOutput("short_rom_loaded", 32'(rom_loaded), 32'd0);
    checkOutput("short_core_held", 32'(core_reset_n), 32'd0);

    romLoad(300, 1'b0, "recover_dn_wr_count");
    waitRelease(0, cnt);
    checkOutput("recover_release_cycles", 32'(cnt), 32'd1025);
    checkOutput("recover_size_err", 32'(rom_size_err), 32'd0);

    romLoad(300, 1'b1, "overrun_dn_wr_count");
    idleCycles(3, 1'b0, ROM_IDX);
    checkOutput("overrun_size_err", 32'(rom_size_err), 32'd1);
    checkOutput("overrun_rom_loaded", 32'(rom_loaded), 32'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b1);
    idleCycles(1200, 1'b0, ROM_IDX);
    checkOutput("err_user_reset_ignored", 32'(core_reset_n), 32'd0);

    romLoad(300, 1'b0, "final_dn_wr_count");
    waitRelease(0, cnt);
    applyStimulus(1'b0, 1'b1, 25'd0, 8'h3C, DIP_IDX, 1'b0);
    idleCycles(2, 1'b0, ROM_IDX);

    // Reset in the middle of a ROM download.
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    for (int a = 0; a < 100; a++) applyStimulus(1'b1, 1'b1, 25'(a), 8'($urandom), ROM_IDX, 1'b0);
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 25'd0, 8'h00, ROM_IDX, 1'b0);
    reset = 1'b0;
    checkOutput("midload_dip_sw", 32'(dip_sw), 32'h00);
    checkOutput("midload_dn_addr", 32'(bus.dn_addr), 32'd0);
    checkOutput("midload_core_reset_n", 32'(core_reset_n), 32'd0);
    idleCycles(5, 1'b1, ROM_IDX);
    idleCycles(20, 1'b0, ROM_IDX);
    checkOutput("midload_end_no_run", 32'(core_reset_n), 32'd0);
    checkOutput("midload_end_no_err", 32'(rom_size_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
